// File: rtl/rf_burst_reader_pkg.sv
// Shared types and defaults for the register-file burst reader.
// Holds the FSM state encoding and the request-length clamp rule.
package rf_burst_reader_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int unsigned RF_WIDTH = 3;
    localparam int unsigned RF_NREGS = 4;

    // A zero length still reads one word; a length beyond the file reads every register once.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nregs);
        if (len == 0) return 1;
        if (len > nregs) return nregs;
        return len;
    endfunction

endpackage

// File: rtl/rf_burst_reader_word_mux.sv
// Combinational NREGS:1 word selector over the flattened register-file outputs.
// Register i occupies i_rf_flat[i*WIDTH +: WIDTH].
module rf_word_mux #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NREGS = 4,
    parameter int unsigned AW    = 2
) (
    input  logic [NREGS*WIDTH-1:0] i_rf_flat,
    input  logic [AW-1:0]          i_addr,
    output logic [WIDTH-1:0]       o_word
);

    always_comb begin
        o_word = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (i_addr == AW'(i)) o_word = i_rf_flat[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/rf_burst_reader.sv
// Read-side burst controller: accepts (addr, len) and streams register words
// through a registered valid/ready output stage at one word per clock.
module rf_burst_reader
    import rf_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] rf_flat,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_addr,
    input  logic [AW:0]            req_len,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [AW-1:0]          rsp_addr,
    output logic                   rsp_last,
    output logic                   busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_addr;
    logic             r_last;
    logic [AW:0]      r_rem;

    logic             w_accept;
    logic             w_hshk;
    logic [AW:0]      w_len_eff;
    logic [AW-1:0]    w_sel_addr;
    logic [WIDTH-1:0] w_word;

    assign w_accept  = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_hshk    = r_valid && rsp_ready;
    assign w_len_eff = (AW+1)'(clamp_len(32'(req_len), NREGS));

    // One mux serves both the first word (request address) and every following word.
    assign w_sel_addr = (r_state == ST_IDLE) ? req_addr : r_addr + AW'(1);

    rf_word_mux #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_word_mux (
        .i_rf_flat (rf_flat),
        .i_addr    (w_sel_addr),
        .o_word    (w_word)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
            ST_SEND: if (w_hshk && r_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_rem counts the words still to follow the one currently held in the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready <= 1'b1;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_last      <= 1'b0;
            r_rem       <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_addr  <= req_addr;
                r_rem   <= w_len_eff - (AW+1)'(1);
                r_last  <= (w_len_eff == (AW+1)'(1));
            end else if (w_hshk) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_data <= w_word;
                    r_addr <= w_sel_addr;
                    r_rem  <= r_rem - (AW+1)'(1);
                    r_last <= (r_rem == (AW+1)'(1));
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_addr  = r_addr;
    assign rsp_last  = r_last;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rf_burst_reader.sv
// Scoreboard bench for rf_burst_reader: expected words are queued when a request
// is issued and compared by a negedge monitor on every output handshake.
module tb_rf_burst_reader;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned NREGS = 4;
    localparam int unsigned AW    = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREGS*WIDTH-1:0] rf_flat;
    logic                   req_valid;
    logic                   req_ready;
    logic [AW-1:0]          req_addr;
    logic [AW:0]            req_len;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [AW-1:0]          rsp_addr;
    logic                   rsp_last;
    logic                   busy;

    logic [WIDTH-1:0] rf_mem [NREGS];

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [AW-1:0]    a;
        logic             l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        rf_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++) rf_flat[i*WIDTH +: WIDTH] = rf_mem[i];
    end

    rf_burst_reader #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rf_flat   (rf_flat),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, plus hold checks after a stalled cycle.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [AW-1:0]    prev_addr;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_valid", rsp_valid, 1);
                    check_eq("hold_data", rsp_data, prev_data);
                    check_eq("hold_addr", rsp_addr, prev_addr);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("extra_word", rsp_valid, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check_eq("rsp_data", rsp_data, mon_e.d);
                        check_eq("rsp_addr", rsp_addr, mon_e.a);
                        check_eq("rsp_last", rsp_last, mon_e.l);
                    end
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
                prev_addr  = rsp_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int unsigned addr, input int unsigned len);
        int unsigned n;
        int unsigned a;
        exp_t        e;
        n = (len == 0) ? 1 : ((len > NREGS) ? NREGS : len);
        for (int unsigned i = 0; i < n; i++) begin
            a   = (addr + i) % NREGS;
            e.d = rf_mem[a];
            e.a = AW'(a);
            e.l = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input int unsigned addr, input int unsigned len);
        int unsigned k;
        k = 0;
        while (!req_ready && k < 20) begin
            tick();
            k++;
        end
        check_eq("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = AW'(addr);
        req_len   = (AW+1)'(len);
        push_burst(addr, len);
        tick();
        req_valid = 1'b0;
        check_eq("lat_valid", rsp_valid, 1);
        check_eq("busy_on", busy, 1);
        check_eq("req_ready_low", req_ready, 0);
    endtask

    task automatic drain(input string tag, input int unsigned exp_cycles);
        int unsigned k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check_eq({tag, "_left"}, sb.size(), 0);
        check_eq({tag, "_cycles"}, k, exp_cycles);
        check_eq({tag, "_end_valid"}, rsp_valid, 0);
        check_eq({tag, "_end_last"}, rsp_last, 0);
        check_eq({tag, "_end_ready"}, req_ready, 1);
        check_eq({tag, "_end_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rf_mem[0] = 3'd1;
        rf_mem[1] = 3'd7;
        rf_mem[2] = 3'd2;
        rf_mem[3] = 3'd5;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_data", rsp_data, 0);
        check_eq("rst_addr", rsp_addr, 0);
        check_eq("rst_last", rsp_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_ready, 1);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // single read
        issue(2, 1);
        check_eq("single_last", rsp_last, 1);
        drain("single", 1);

        // wrapping burst, one word per clock
        issue(2, 4);
        drain("wrap", 4);

        // backpressure with register change during the stall
        rsp_ready = 1'b0;
        issue(0, 2);
        rf_mem[0] = 3'd6;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_data", rsp_data, 1);
        end
        rsp_ready = 1'b1;
        drain("bp", 2);
        rf_mem[0] = 3'd1;

        // length edges
        issue(3, 0);
        drain("len0", 1);
        issue(1, 7);
        drain("len7", 4);

        // second request during a burst is ignored
        issue(0, 4);
        req_valid = 1'b1;
        req_addr  = 2'd3;
        req_len   = 3'd1;
        for (int unsigned i = 0; i < 2; i++) begin
            check_eq("ovl_req_ready", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        drain("ovl", 2);
        for (int unsigned i = 0; i < 3; i++) tick();
        check_eq("ovl_quiet", rsp_valid, 0);

        // reset in the middle of the third word
        issue(0, 4);
        tick();
        tick();
        check_eq("pre_rst_addr", rsp_addr, 2);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        check_eq("mrst_valid", rsp_valid, 0);
        check_eq("mrst_data", rsp_data, 0);
        check_eq("mrst_addr", rsp_addr, 0);
        check_eq("mrst_last", rsp_last, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_ready", req_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        check_eq("post_rst_ready", req_ready, 1);
        issue(1, 2);
        drain("post_rst", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
